// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the UART path.
package uart_pkg;
    localparam logic MODE_TX         = 1'b0;
    localparam logic MODE_RX         = 1'b1;
    localparam int   DIV_MIN         = 2;
    localparam int   DIV_W_DEF       = 16;
    localparam int   NBITS_W_DEF     = 4;
    localparam int   BAUD_115200_DIV = 5208;
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: times one serial frame and emits one tick per bit
// at bit start (TX) or bit centre (RX).
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int DIV_W   = DIV_W_DEF,
    parameter int NBITS_W = NBITS_W_DEF
) (
    input  logic               sysclk,
    input  logic               reset,
    input  logic               trigger,
    input  logic               enable,
    input  logic               mode,
    input  logic [DIV_W-1:0]   divisor,
    input  logic [NBITS_W-1:0] nbits,
    output logic               busy,
    output logic               bit_tick,
    output logic [NBITS_W-1:0] bit_index,
    output logic               finish
);
    logic               busy_q, busy_d;
    logic               finish_q, finish_d;
    logic               mode_q, mode_d;
    logic [DIV_W-1:0]   phase_q, phase_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [NBITS_W-1:0] idx_q, idx_d;
    logic [NBITS_W-1:0] nb_q, nb_d;
    logic [DIV_W-1:0]   tick_phase;

    always_comb begin
        busy_d   = busy_q;
        phase_d  = phase_q;
        idx_d    = idx_q;
        div_d    = div_q;
        nb_d     = nb_q;
        mode_d   = mode_q;
        finish_d = 1'b0;
        if (!busy_q) begin
            if (trigger && enable) begin
                busy_d  = 1'b1;
                phase_d = '0;
                idx_d   = '0;
                div_d   = (divisor < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : divisor;
                nb_d    = (nbits == '0) ? NBITS_W'(1) : nbits;
                mode_d  = mode;
            end
        end else if (!enable) begin
            busy_d  = 1'b0;
            phase_d = '0;
            idx_d   = '0;
        end else if (phase_q == div_q - DIV_W'(1)) begin
            phase_d = '0;
            if (idx_q == nb_q - NBITS_W'(1)) begin
                busy_d   = 1'b0;
                idx_d    = '0;
                finish_d = 1'b1;
            end else begin
                idx_d = idx_q + NBITS_W'(1);
            end
        end else begin
            phase_d = phase_q + DIV_W'(1);
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            busy_q   <= 1'b0;
            finish_q <= 1'b0;
            mode_q   <= MODE_TX;
            phase_q  <= '0;
            div_q    <= DIV_W'(DIV_MIN);
            idx_q    <= '0;
            nb_q     <= NBITS_W'(1);
        end else begin
            busy_q   <= busy_d;
            finish_q <= finish_d;
            mode_q   <= mode_d;
            phase_q  <= phase_d;
            div_q    <= div_d;
            idx_q    <= idx_d;
            nb_q     <= nb_d;
        end
    end

    // Ticks decode straight from registers, so one decoded in an abort cycle still shows.
    assign tick_phase = (mode_q == MODE_RX) ? (div_q >> 1) : '0;
    assign bit_tick   = busy_q && (phase_q == tick_phase);
    assign busy       = busy_q;
    assign bit_index  = idx_q;
    assign finish     = finish_q;
endmodule

// File: tb/tb_uart_bit_timer.sv
// tb_uart_bit_timer: table-driven, hand-written and random frames checked
// against an arithmetic model of frame timing.
module tb_uart_bit_timer;
    logic        sysclk = 1'b0;
    logic        reset, trigger, enable, mode;
    logic [15:0] divisor;
    logic [3:0]  nbits;
    logic        busy, bit_tick, finish;
    logic [3:0]  bit_index;
    int          checks = 0;
    int          failures = 0;

    uart_bit_timer #(.DIV_W(16), .NBITS_W(4)) dut (
        .sysclk(sysclk), .reset(reset), .trigger(trigger), .enable(enable),
        .mode(mode), .divisor(divisor), .nbits(nbits), .busy(busy),
        .bit_tick(bit_tick), .bit_index(bit_index), .finish(finish)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        logic m;
        int   dv;
        int   nb;
        int   ab;
        int   len;
        int   ticks;
    } vec_t;

    vec_t vt[7];

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_idle(input string name, input logic fin);
        chk({name, "_busy"}, 32'(busy), 32'(0));
        chk({name, "_tick"}, 32'(bit_tick), 32'(0));
        chk({name, "_idx"}, 32'(bit_index), 32'(0));
        chk({name, "_finish"}, 32'(finish), 32'(fin));
    endtask

    // Starts from an idle sample point; ab < 0 means no abort, else enable drops in busy cycle ab.
    task automatic run_frame(input logic m, input int dv, input int nb, input int ab,
                             input bit scramble, output int act_len, output int act_ticks);
        int d, n, tp, len;
        d  = (dv < 2) ? 2 : dv;
        n  = (nb < 1) ? 1 : nb;
        tp = m ? d / 2 : 0;
        len = (ab >= 0) ? ab + 1 : n * d;
        act_len = 0;
        act_ticks = 0;
        mode = m; divisor = 16'(dv); nbits = 4'(nb); trigger = 1'b1; enable = 1'b1;
        step();
        trigger = 1'b0;
        for (int c = 0; c < len; c++) begin
            chk("frame_busy", 32'(busy), 32'(1));
            chk("frame_tick", 32'(bit_tick), 32'((c % d) == tp));
            chk("frame_idx", 32'(bit_index), 32'(c / d));
            chk("frame_finish", 32'(finish), 32'(0));
            act_len += int'(busy);
            act_ticks += int'(bit_tick);
            if (scramble) begin
                trigger = 1'($urandom);
                divisor = 16'($urandom);
                nbits   = 4'($urandom);
                mode    = 1'($urandom);
            end
            enable = (c == ab) ? 1'b0 : 1'b1;
            step();
        end
        trigger = 1'b0;
        enable = 1'b1;
        chk_idle("end", ab < 0);
        step();
        chk_idle("after", 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int al, at, d, n, b;
        vt[0] = '{1'b0, 4, 10, -1, 40, 10};
        vt[1] = '{1'b1, 5, 3, -1, 15, 3};
        vt[2] = '{1'b0, 1, 2, -1, 4, 2};
        vt[3] = '{1'b1, 6, 0, -1, 6, 1};
        vt[4] = '{1'b0, 8, 10, 20, 21, 3};
        vt[5] = '{1'b1, 8, 10, 20, 21, 3};
        vt[6] = '{1'b1, 0, 1, -1, 2, 1};
        reset = 1'b1; trigger = 1'b0; enable = 1'b0; mode = 1'b0;
        divisor = '0; nbits = '0;
        step();
        step();
        chk_idle("reset", 1'b0);
        reset = 1'b0;
        step();

        foreach (vt[i]) begin
            run_frame(vt[i].m, vt[i].dv, vt[i].nb, vt[i].ab, 1'b1, al, at);
            chk("tbl_len", 32'(al), 32'(vt[i].len));
            chk("tbl_ticks", 32'(at), 32'(vt[i].ticks));
        end

        // Back-to-back: trigger held, two 6-cycle frames split by one finish cycle.
        mode = 1'b0; divisor = 16'd3; nbits = 4'd2; enable = 1'b1; trigger = 1'b1;
        step();
        for (int c = 0; c < 14; c++) begin
            b = c % 7;
            chk("b2b_busy", 32'(busy), 32'(b != 6));
            chk("b2b_finish", 32'(finish), 32'(c == 6 || c == 13));
            chk("b2b_tick", 32'(bit_tick), 32'(b != 6 && (b % 3) == 0));
            chk("b2b_idx", 32'(bit_index), 32'((b != 6) ? b / 3 : 0));
            trigger = (c < 10) ? 1'b1 : 1'b0;
            step();
        end
        chk_idle("b2b_end", 1'b0);

        // Reset mid-frame clears outputs without waiting for an edge.
        mode = 1'b0; divisor = 16'd4; nbits = 4'd10; trigger = 1'b1;
        step();
        trigger = 1'b0;
        repeat (5) step();
        chk("pre_rst_busy", 32'(busy), 32'(1));
        chk("pre_rst_idx", 32'(bit_index), 32'(1));
        #2 reset = 1'b1;
        #1 chk_idle("async_rst", 1'b0);
        step();
        reset = 1'b0;
        run_frame(1'b0, 3, 2, -1, 1'b0, al, at);
        chk("post_rst_len", 32'(al), 32'(6));
        chk("post_rst_ticks", 32'(at), 32'(2));

        for (int r = 0; r < 20; r++) begin
            d = $urandom_range(0, 12);
            n = $urandom_range(0, 15);
            b = ($urandom_range(0, 2) == 0) ? $urandom_range(0, ((d < 2) ? 2 : d) * ((n < 1) ? 1 : n) - 1) : -1;
            run_frame(1'($urandom), d, n, b, 1'b1, al, at);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_bit_timer.md
# uart_bit_timer

Parametrised bit-timing generator for the UART path: on a trigger it times one serial frame of a runtime-selectable bit count and per-bit period. It emits one tick per bit, either at each bit start (TX) or at each bit centre (RX sampling). It sits between the UART shift registers and the system clock, replacing the fixed-rate, fixed-frame baud generator. It adds runtime divisor, frame length, RX/TX tick placement, bit index output, abort, and back-to-back frames.

## Interface

- DIV_W, 16: width of the divisor (cycles per bit).
- NBITS_W, 4: width of frame bit count and bit index.
- sysclk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- trigger  input  1  start request; accepted only when idle and enable=1.
- enable  input  1  block enable; low while busy aborts the frame.
- mode  input  1  0 = TX (tick at bit start), 1 = RX (tick at bit centre); latched at start.
- divisor  input  DIV_W  cycles per bit; latched at start.
- nbits  input  NBITS_W  bits per frame including start/stop; latched at start.
- busy  output  1  frame in progress.
- bit_tick  output  1  one-cycle pulse per bit.
- bit_index  output  NBITS_W  index of current bit (0 = first); 0 when idle.
- finish  output  1  one-cycle pulse on normal frame completion.

## Operation

- Registers: busy, phase (DIV_W), bit_index, latched div/nbits/mode, finish.
- Idle → Run: edge where busy=0 & trigger=1 & enable=1. Latch div = max(divisor, 2), nb = max(nbits, 1), mode. Set phase=0, bit_index=0, busy=1.
- Run: phase increments each cycle. At phase = div-1: phase→0, bit_index+1.
- Last bit: at phase = div-1 & bit_index = nb-1 → busy=0, bit_index=0, finish=1 for one cycle.
- Abort: enable=0 while busy → busy=0, phase=0, bit_index=0 next edge; no finish, no further ticks.
- bit_tick = busy & (phase == tick_phase), decoded from registers. tick_phase = 0 (TX) or floor(div/2) (RX).
- trigger while busy is ignored; divisor/nbits/mode changes while busy have no effect.
- Reset: busy=0, bit_tick=0, bit_index=0, finish=0, phase=0; takes effect immediately, including mid-frame.

## Timing

- Trigger accepted at edge E0 → busy high from E0 for exactly nb*div cycles.
- TX: ticks in busy cycles k*div (k = 0..nb-1); the first tick occurs in the cycle directly after E0.
- RX: ticks in busy cycles k*div + floor(div/2).
- finish is high in the first cycle with busy=0 after the frame ends.
- Back-to-back: trigger & enable in the finish cycle is accepted. The next frame's busy starts one cycle later, so the idle gap is one cycle.
- Abort has one-cycle latency. A tick decoded in the abort-request cycle is still emitted.
- phase and bit_index never wrap past div-1 / nb-1.

## Structure

- Shared package uart_pkg:
  - MODE_TX = 1'b0, MODE_RX = 1'b1.
  - DIV_MIN = 2.
  - Default DIV_W/NBITS_W.
  - Divisor constant for 115200 baud at the system clock (5208 at 600 MHz-equivalent frame rate currently used).
- Single module; no sub-module is warranted. The phase counter and bit counter are one control process.

## Test plan

- TX, divisor=4, nbits=10: busy 40 cycles, 10 ticks at busy cycles 0,4,…,36, bit_index 0..9, finish pulse at cycle 40.
- RX, divisor=5, nbits=3: ticks at busy cycles 2,7,12; busy 15 cycles; one finish pulse.
- Clamping:
  - divisor=1, nbits=2 → behaves as divisor=2: busy 4 cycles, ticks at 0,2.
  - nbits=0 → one bit.
- Abort: divisor=8, nbits=10, enable low at busy cycle 20 → busy falls next edge, no finish, no ticks after cycle 20, bit_index=0.
- Back-to-back: trigger held high, divisor=3, nbits=2 → two frames of 6 cycles separated by one idle (finish) cycle. Retrigger mid-frame is ignored.
- Reset at busy cycle 5 → all outputs zero immediately. A trigger after release starts a clean frame with the new latched divisor.
